exu_div_seq: RTL and testbench

//  Multi-cycle sequencer for RV64M DIV/DIVU/REM/REMU and the *W variants.

---
 rtl/exu_div_seq_pkg.sv | 29 ++
 rtl/exu_div_seq_alu.sv | 31 +++
 rtl/exu_div_seq.sv | 177 +++++++++++++++++
 tb/tb_exu_div_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_div_seq_pkg.sv
// Shared constants for the sequential RV64M divider: operation codes,
// sequencer state encodings and the ALU operation selects.
package exu_div_seq_pkg;

   localparam int XLEN  = 64;
   localparam int CNT_W = $clog2(XLEN);

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_ST_IDLE = 2'b00,
      DIV_ST_CALC = 2'b01,
      DIV_ST_FIX  = 2'b10,
      DIV_ST_DONE = 2'b11
   } div_state_e;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_SUBU = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4,
      ALU_XOR  = 3'd5
   } alu_op_e;

endpackage

// File: rtl/exu_div_seq_alu.sv
// Small combinational ALU. The divider uses it in SUBU mode, where the
// borrow output tells whether the trial subtraction went negative.
module exu_div_seq_alu
   import exu_div_seq_pkg::*;
(
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  alu_op_e         opt,
   output logic [XLEN-1:0] res,
   output logic            sububit
);

   logic [XLEN:0] diff_ext;

   assign diff_ext = {1'b0, src1} - {1'b0, src2};
   assign sububit  = diff_ext[XLEN];

   // Select the result for the requested operation.
   always_comb begin
      res = '0;
      case (opt)
         ALU_ADD:            res = src1 + src2;
         ALU_SUB, ALU_SUBU:  res = diff_ext[XLEN-1:0];
         ALU_AND:            res = src1 & src2;
         ALU_OR:             res = src1 | src2;
         ALU_XOR:            res = src1 ^ src2;
         default:            res = '0;
      endcase
   end

endmodule

// File: rtl/exu_div_seq.sv
// Multi-cycle RV64M divider (DIV/DIVU/REM/REMU and W forms). Restoring
// division on operand magnitudes, one quotient bit per cycle, followed by
// a sign fixup. Divide-by-zero and signed overflow bypass the loop.
module exu_div_seq
   import exu_div_seq_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [1:0]      i_op,
   input  logic            i_word,
   input  logic [XLEN-1:0] i_src1,
   input  logic [XLEN-1:0] i_src2,
   output logic            o_valid,
   input  logic            i_resp_ready,
   output logic [XLEN-1:0] o_res,
   output logic            o_busy
);

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
      return {{(XLEN-32){1'b0}}, v};
   endfunction

   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1);
   endfunction

   div_state_e state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  rem, dvd, divisor, res;
   logic             op_rem, op_word, q_neg, r_neg;

   logic            is_signed, is_rem;
   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val;
   logic [XLEN-1:0] dvd_res, special_res;
   logic            a_neg, b_neg, div_zero, ovf, special;

   logic            top, take, sububit;
   logic [XLEN-1:0] shl, alu_res;
   logic [XLEN-1:0] q_fix, r_fix, fix_sel, fix_res;

   // Operand decode for a new request: extension, signs, magnitudes and the fast-path cases.
   assign is_signed   = !((i_op == DIV_OP_DIVU) || (i_op == DIV_OP_REMU));
   assign is_rem      = !((i_op == DIV_OP_DIV) || (i_op == DIV_OP_DIVU));
   assign a_ext       = i_word ? (is_signed ? sext32(i_src1[31:0]) : zext32(i_src1[31:0])) : i_src1;
   assign b_ext       = i_word ? (is_signed ? sext32(i_src2[31:0]) : zext32(i_src2[31:0])) : i_src2;
   assign a_neg       = is_signed && a_ext[XLEN-1];
   assign b_neg       = is_signed && b_ext[XLEN-1];
   assign a_abs       = a_neg ? negate(a_ext) : a_ext;
   assign b_abs       = b_neg ? negate(b_ext) : b_ext;
   assign min_val     = i_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
   assign div_zero    = (b_ext == '0);
   assign ovf         = is_signed && (a_ext == min_val) && (b_ext == '1);
   assign special     = div_zero || ovf;
   assign dvd_res     = i_word ? sext32(i_src1[31:0]) : i_src1;
   assign special_res = div_zero ? (is_rem ? dvd_res : '1)
                                 : (is_rem ? '0 : dvd_res);

   // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
   assign top  = rem[XLEN-1];
   assign shl  = {rem[XLEN-2:0], dvd[XLEN-1]};
   assign take = top | ~sububit;

   exu_div_seq_alu u_alu (
      .src1    (shl),
      .src2    (divisor),
      .opt     (ALU_SUBU),
      .res     (alu_res),
      .sububit (sububit)
   );

   // Sign fixup applied once the loop has finished.
   assign q_fix   = q_neg ? negate(dvd) : dvd;
   assign r_fix   = r_neg ? negate(rem) : rem;
   assign fix_sel = op_rem ? r_fix : q_fix;
   assign fix_res = op_word ? sext32(fix_sel[31:0]) : fix_sel;

   // State register; flush and reset both return the sequencer to idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= DIV_ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection and handshake outputs; a flush overrides everything, including an accept.
   always_comb begin
      state_nxt = state;
      o_ready   = 1'b0;
      o_busy    = 1'b0;
      o_valid   = 1'b0;
      case (state)
         DIV_ST_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               state_nxt = special ? DIV_ST_DONE : DIV_ST_CALC;
            end
         end
         DIV_ST_CALC: begin
            o_busy = 1'b1;
            if (cnt == '0) begin
               state_nxt = DIV_ST_FIX;
            end
         end
         DIV_ST_FIX: begin
            o_busy    = 1'b1;
            state_nxt = DIV_ST_DONE;
         end
         DIV_ST_DONE: begin
            o_busy  = 1'b1;
            o_valid = 1'b1;
            if (i_resp_ready) begin
               state_nxt = DIV_ST_IDLE;
            end
         end
         default: state_nxt = DIV_ST_IDLE;
      endcase
      if (i_flush) begin
         state_nxt = DIV_ST_IDLE;
      end
   end

   // Datapath: latch operands on accept, iterate in CALC, fix signs in FIX, hold the result in DONE.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         cnt     <= '0;
         res     <= '0;
         rem     <= '0;
         dvd     <= '0;
         divisor <= '0;
         op_rem  <= 1'b0;
         op_word <= 1'b0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         case (state)
            DIV_ST_IDLE: begin
               if (i_valid) begin
                  op_rem  <= is_rem;
                  op_word <= i_word;
                  q_neg   <= is_signed && (a_neg ^ b_neg);
                  r_neg   <= a_neg;
                  rem     <= '0;
                  dvd     <= a_abs;
                  divisor <= b_abs;
                  cnt     <= CNT_W'(XLEN-1);
                  if (special) begin
                     res <= special_res;
                  end
               end
            end
            DIV_ST_CALC: begin
               rem <= take ? alu_res : shl;
               dvd <= {dvd[XLEN-2:0], take};
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DIV_ST_FIX: begin
               res <= fix_res;
            end
            default: ;
         endcase
      end
   end

   assign o_res = res;

endmodule

// File: tb/tb_exu_div_seq.sv
// Self-checking bench for exu_div_seq: directed corner cases plus random
// operations, checked by a scoreboard against an arithmetic reference model.
module tb_exu_div_seq;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;
   localparam int LAT_NORMAL  = 66;
   localparam int LAT_SPECIAL = 1;

   logic        clk = 1'b0;
   logic        rst, flush, valid, word, resp_ready;
   logic [1:0]  op;
   logic [63:0] src1, src2;
   logic        ready, o_valid, busy;
   logic [63:0] res;

   typedef struct {
      logic [63:0] res;
      int          acc_cyc;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   bit   front_seen = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   exu_div_seq dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_flush      (flush),
      .i_valid      (valid),
      .o_ready      (ready),
      .i_op         (op),
      .i_word       (word),
      .i_src1       (src1),
      .i_src2       (src2),
      .o_valid      (o_valid),
      .i_resp_ready (resp_ready),
      .o_res        (res),
      .o_busy       (busy)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Overall time limit so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: RISC-V M-extension division rules written as plain arithmetic.
   function automatic logic [63:0] refDiv(input logic [1:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
      logic        sgn, is_rem;
      logic [31:0] a32, b32, r32;
      logic [63:0] r64;
      sgn    = (o == OP_DIV) || (o == OP_REM);
      is_rem = (o == OP_REM) || (o == OP_REMU);
      a32 = a[31:0];
      b32 = b[31:0];
      if (w) begin
         if (b32 == 32'd0)
            r32 = is_rem ? a32 : 32'hFFFF_FFFF;
         else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
            r32 = is_rem ? 32'd0 : a32;
         else if (sgn)
            r32 = is_rem ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
         else
            r32 = is_rem ? a32 % b32 : a32 / b32;
         return {{32{r32[31]}}, r32};
      end
      if (b == 64'd0)
         r64 = is_rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
         r64 = is_rem ? 64'd0 : a;
      else if (sgn)
         r64 = is_rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      else
         r64 = is_rem ? a % b : a / b;
      return r64;
   endfunction

   function automatic bit isSpecial(input logic [1:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
      bit sgn;
      sgn = (o == OP_DIV) || (o == OP_REM);
      if (w)
         return (b[31:0] == 32'd0) ||
                (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      return (b == 64'd0) ||
             (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
   endfunction

   // Scoreboard: queue the expectation when an accept is about to happen, compare whenever a result is shown.
   always @(negedge clk) begin
      exp_t e;
      if (rst || flush) begin
         exp_q.delete();
         front_seen = 1'b0;
      end else begin
         if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_valid", 64'd1, 64'd0);
            end else begin
               checkOutput("result", res, exp_q[0].res);
               checkOutput("ready_while_valid", {63'd0, ready}, 64'd0);
               if (!front_seen) begin
                  checkOutput("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
                  front_seen = 1'b1;
               end
               if (resp_ready) begin
                  void'(exp_q.pop_front());
                  front_seen = 1'b0;
               end
            end
         end
         if (valid && ready === 1'b1) begin
            e.res     = refDiv(op, word, src1, src2);
            e.acc_cyc = cyc;
            e.lat     = isSpecial(op, word, src1, src2) ? LAT_SPECIAL : LAT_NORMAL;
            exp_q.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issueOp(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
      int t;
      t = 0;
      while (ready !== 1'b1 && t < 100) begin
         step();
         t++;
      end
      checkOutput("ready_timeout", {63'd0, ready}, 64'd1);
      op    = o;
      word  = w;
      src1  = a;
      src2  = b;
      valid = 1'b1;
      step();
      valid = 1'b0;
   endtask

   task automatic waitResult(input int hold);
      int t;
      t = 0;
      while (o_valid !== 1'b1 && t < 100) begin
         step();
         t++;
      end
      if (o_valid !== 1'b1) begin
         checkOutput("valid_timeout", {63'd0, o_valid}, 64'd1);
      end else begin
         repeat (hold) step();
         resp_ready = 1'b1;
         step();
         resp_ready = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic [1:0] o, input logic w, input logic [63:0] a,
                                input logic [63:0] b, input int hold);
      resp_ready = 1'b0;
      issueOp(o, w, a, b);
      waitResult(hold);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
      checkOutput({tag, "_busy"},  {63'd0, busy},    64'd0);
      checkOutput({tag, "_ready"}, {63'd0, ready},   64'd1);
      checkOutput({tag, "_res"},   res,              64'd0);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic        r_w;
      logic [63:0] r_a, r_b;

      rst = 1'b1; flush = 1'b0; valid = 1'b0; op = 2'b00; word = 1'b0;
      src1 = '0; src2 = '0; resp_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      checkIdle("reset");

      $display("[TB] directed cases");
      applyStimulus(OP_DIVU, 1'b0, 64'd100, 64'd7, 0);
      applyStimulus(OP_REMU, 1'b0, 64'd100, 64'd7, 0);
      applyStimulus(OP_DIV,  1'b0, -64'sd7, 64'd2, 0);
      applyStimulus(OP_REM,  1'b0, -64'sd7, 64'd2, 1);
      applyStimulus(OP_DIV,  1'b0, 64'd5, 64'd0, 0);
      applyStimulus(OP_REMU, 1'b0, 64'd5, 64'd0, 0);
      applyStimulus(OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      applyStimulus(OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      applyStimulus(OP_DIV,  1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      applyStimulus(OP_REMU, 1'b1, 64'hFFFF_FFFF, 64'h10, 0);
      applyStimulus(OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 0);
      applyStimulus(OP_REMU, 1'b1, 64'hABCD_0000_1234_5678, 64'hFFFF_0000_0000_0000, 0);

      $display("[TB] result held while consumer stalls");
      applyStimulus(OP_DIVU, 1'b0, 64'd1000, 64'd3, 5);

      $display("[TB] flush in CALC");
      resp_ready = 1'b0;
      issueOp(OP_DIVU, 1'b0, 64'd12345, 64'd11);
      repeat (9) step();
      checkOutput("calc_busy",  {63'd0, busy},  64'd1);
      checkOutput("calc_ready", {63'd0, ready}, 64'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      checkIdle("flush");
      repeat (80) step();
      checkOutput("flush_no_valid", {63'd0, o_valid}, 64'd0);

      $display("[TB] flush coincident with request");
      valid = 1'b1; flush = 1'b1; op = OP_DIV; word = 1'b0; src1 = 64'd9; src2 = 64'd0;
      step();
      valid = 1'b0; flush = 1'b0;
      checkIdle("flush_accept");
      repeat (3) step();
      checkOutput("flush_accept_no_valid", {63'd0, o_valid}, 64'd0);

      $display("[TB] reset in CALC");
      applyStimulus(OP_DIVU, 1'b0, 64'd77, 64'd5, 0);
      issueOp(OP_REM, 1'b0, 64'd999, 64'd13);
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkIdle("rst_calc");
      repeat (80) step();
      checkOutput("rst_no_valid", {63'd0, o_valid}, 64'd0);

      $display("[TB] random operations");
      for (int i = 0; i < 30; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_w  = 1'($urandom_range(0, 1));
         r_a  = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0: r_b = {$urandom, $urandom};
            1: begin
               r_b = 64'($urandom_range(1, 20));
               if ($urandom_range(0, 1) == 1) r_b = -r_b;
            end
            2: r_b = r_w ? {$urandom, 32'd0} : 64'd0;
            3: begin
               r_a = r_w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
               r_b = r_w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
            end
            default: r_b = {$urandom, $urandom} >> $urandom_range(0, 63);
         endcase
         applyStimulus(r_op, r_w, r_a, r_b, $urandom_range(0, 3));
      end

      repeat (3) step();
      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
